// File: rtl/arm_pkg.sv
// Shared ARM decode constants: condition codes, NZCV bit positions and ALU command encodings.
package arm_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam logic [1:0] FLAG_N = 2'd3;
  localparam logic [1:0] FLAG_Z = 2'd2;
  localparam logic [1:0] FLAG_C = 2'd1;
  localparam logic [1:0] FLAG_V = 2'd0;

  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

endpackage

// File: rtl/id_ex_stage_reg_condition_check.sv
// ARM condition-code evaluator: decides whether an instruction executes under the current NZCV flags.
module condition_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       cond_pass
);

  logic n, z, c, v;

  assign n = status[FLAG_N];
  assign z = status[FLAG_Z];
  assign c = status[FLAG_C];
  assign v = status[FLAG_V];

  always_comb begin
    cond_pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c & !z;
      COND_LS: cond_pass = !c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register; control bits are gated by condition pass and hazard bubbles,
// with flush taking priority over freeze.
module id_ex_stage_reg
  import arm_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              hazard,
  input  logic [3:0]        cond,
  input  logic [3:0]        status,
  input  logic [3:0]        exe_cmd_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wb_en_in,
  input  logic              b_in,
  input  logic              status_we_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm24_in,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [REG_W-1:0]  src1_in,
  input  logic [REG_W-1:0]  src2_in,
  output logic [3:0]        exe_cmd_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              wb_en_out,
  output logic              b_out,
  output logic              status_we_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm24_out,
  output logic [REG_W-1:0]  dest_out,
  output logic [REG_W-1:0]  src1_out,
  output logic [REG_W-1:0]  src2_out,
  output logic              valid_out,
  output logic              cond_pass
);

  logic gate;

  condition_check u_condition_check (
    .cond      (cond),
    .status    (status),
    .cond_pass (cond_pass)
  );

  assign gate = cond_pass & !hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      // flush is checked ahead of freeze so a branch kill is never delayed by a stall
      exe_cmd_out       <= '0;
      mem_read_out      <= 1'b0;
      mem_write_out     <= 1'b0;
      wb_en_out         <= 1'b0;
      b_out             <= 1'b0;
      status_we_out     <= 1'b0;
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      imm_out           <= 1'b0;
      shift_operand_out <= '0;
      signed_imm24_out  <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      valid_out         <= 1'b0;
    end else if (!freeze) begin
      exe_cmd_out       <= exe_cmd_in & {4{gate}};
      mem_read_out      <= mem_read_in & gate;
      mem_write_out     <= mem_write_in & gate;
      wb_en_out         <= wb_en_in & gate;
      b_out             <= b_in & gate;
      status_we_out     <= status_we_in & gate;
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      imm_out           <= imm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm24_out  <= signed_imm24_in;
      dest_out          <= dest_in;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      valid_out         <= gate;
    end
  end

endmodule
